// File: rtl/game_seq_ctrl.sv
// game_seq_ctrl: game state, level and lives sequencer for the raccoon road-crossing game.
// Freezes play during hit/level-up pauses and pulses a respawn on every return to PLAY.
module game_seq_ctrl #(
    parameter int unsigned NUM_LIVES  = 3,
    parameter int unsigned MAX_LEVEL  = 9,
    parameter logic [9:0]  GOAL_Y     = 10'd0,
    parameter int unsigned HIT_CYCLES = 25_000_000,
    parameter int unsigned LVL_CYCLES = 12_500_000
) (
    input  logic       i_Clk,
    input  logic       i_Reset_n,
    input  logic       i_Start,
    input  logic       i_Collision,
    input  logic [9:0] i_Raccoon_Y,
    output logic [2:0] o_State,
    output logic [3:0] o_Level,
    output logic [3:0] o_Level_Units,
    output logic [3:0] o_Level_Tens,
    output logic [2:0] o_Lives,
    output logic       o_Freeze,
    output logic       o_Respawn
);
    localparam int unsigned TMAX = (HIT_CYCLES > LVL_CYCLES) ? HIT_CYCLES : LVL_CYCLES;
    localparam int TW = $clog2(TMAX + 1);
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_PLAY = 3'd1;
    localparam logic [2:0] S_HIT  = 3'd2;
    localparam logic [2:0] S_LVL  = 3'd3;
    localparam logic [2:0] S_OVER = 3'd4;

    logic [2:0]    state_q, state_d;
    logic [3:0]    level_q, level_d;
    logic [2:0]    lives_q, lives_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          coll_q, respawn_d, rise, tens_d;

    assign rise   = i_Collision & ~coll_q;
    assign tens_d = level_d >= 4'd10;

    always_comb begin
        state_d   = state_q;
        level_d   = level_q;
        lives_d   = lives_q;
        timer_d   = timer_q;
        respawn_d = 1'b0;
        case (state_q)
            S_IDLE: if (i_Start) begin
                state_d   = S_PLAY;
                respawn_d = 1'b1;
            end
            // a collision outranks reaching the goal in the same cycle
            S_PLAY: if (rise) begin
                lives_d = lives_q - 3'd1;
                state_d = (lives_q == 3'd1) ? S_OVER : S_HIT;
                timer_d = TW'(HIT_CYCLES - 1);
            end else if (i_Raccoon_Y <= GOAL_Y) begin
                level_d = (level_q == 4'(MAX_LEVEL)) ? 4'd1 : level_q + 4'd1;
                state_d = S_LVL;
                timer_d = TW'(LVL_CYCLES - 1);
            end
            S_HIT, S_LVL: if (timer_q == '0) begin
                state_d   = S_PLAY;
                respawn_d = 1'b1;
            end else begin
                timer_d = timer_q - 1'b1;
            end
            S_OVER: if (i_Start) begin
                state_d = S_IDLE;
                level_d = 4'd1;
                lives_d = 3'(NUM_LIVES);
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            state_q       <= S_IDLE;
            level_q       <= 4'd1;
            lives_q       <= 3'(NUM_LIVES);
            timer_q       <= '0;
            coll_q        <= 1'b0;
            o_Freeze      <= 1'b1;
            o_Respawn     <= 1'b0;
            o_Level_Units <= 4'd1;
            o_Level_Tens  <= 4'd0;
        end else begin
            state_q       <= state_d;
            level_q       <= level_d;
            lives_q       <= lives_d;
            timer_q       <= timer_d;
            coll_q        <= i_Collision;
            o_Freeze      <= state_d != S_PLAY;
            o_Respawn     <= respawn_d;
            o_Level_Units <= tens_d ? level_d - 4'd10 : level_d;
            o_Level_Tens  <= {3'd0, tens_d};
        end
    end

    assign o_State = state_q;
    assign o_Level = level_q;
    assign o_Lives = lives_q;
endmodule

// File: tb/tb_game_seq_ctrl.sv
// tb_game_seq_ctrl: directed and random stimulus against a behavioural game model,
// compared on every falling clock edge, plus hand-computed literal expectations.
module tb_game_seq_ctrl;
    localparam int HITC = 4, LVLC = 3, NL = 3, ML = 9;

    logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0, coll = 1'b0;
    logic [9:0] y = 10'd500;
    logic [2:0] o_State, o_Lives;
    logic [3:0] o_Level, o_Units, o_Tens;
    logic       o_Freeze, o_Respawn;
    int errors = 0, checks = 0;

    game_seq_ctrl #(.NUM_LIVES(NL), .MAX_LEVEL(ML), .GOAL_Y(10'd0),
                    .HIT_CYCLES(HITC), .LVL_CYCLES(LVLC)) dut (
        .i_Clk(clk), .i_Reset_n(rst_n), .i_Start(start), .i_Collision(coll),
        .i_Raccoon_Y(y), .o_State(o_State), .o_Level(o_Level),
        .o_Level_Units(o_Units), .o_Level_Tens(o_Tens), .o_Lives(o_Lives),
        .o_Freeze(o_Freeze), .o_Respawn(o_Respawn)
    );

    always #5 clk = ~clk;

    // pause counts the frozen cycles still to come, not a hardware timer value
    typedef struct packed {int st; int lives; int level; int pause; bit prev; bit resp;} mdl_t;

    function automatic mdl_t mreset();
        mdl_t r;
        r.st = 0; r.lives = NL; r.level = 1; r.pause = 0; r.prev = 0; r.resp = 0;
        return r;
    endfunction

    function automatic mdl_t mstep(mdl_t s, bit st_i, bit c, int yy);
        mdl_t n = s;
        bit rise = c && !s.prev;
        n.prev = c;
        n.resp = 0;
        if (s.st == 0 && st_i) begin
            n.st = 1; n.resp = 1;
        end else if (s.st == 1 && rise) begin
            n.lives = s.lives - 1;
            n.st = (n.lives == 0) ? 4 : 2;
            n.pause = HITC;
        end else if (s.st == 1 && yy <= 0) begin
            n.level = s.level % ML + 1;
            n.st = 3;
            n.pause = LVLC;
        end else if (s.st == 2 || s.st == 3) begin
            n.pause = s.pause - 1;
            if (n.pause == 0) begin n.st = 1; n.resp = 1; end
        end else if (s.st == 4 && st_i) begin
            n.st = 0; n.level = 1; n.lives = NL;
        end
        return n;
    endfunction

    mdl_t m = mreset();
    always @(posedge clk or negedge rst_n) m <= !rst_n ? mreset() : mstep(m, start, coll, int'(y));

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        chk("m_state", o_State, m.st);
        chk("m_lives", o_Lives, m.lives);
        chk("m_level", o_Level, m.level);
        chk("m_units", o_Units, m.level % 10);
        chk("m_tens", o_Tens, m.level / 10);
        chk("m_freeze", o_Freeze, m.st != 1);
        chk("m_respawn", o_Respawn, m.resp);
    end

    task automatic cyc(bit s, bit c, logic [9:0] yy);
        start = s; coll = c; y = yy;
        @(negedge clk);
    endtask

    initial begin
        int cnt, rsp;
        repeat (2) @(negedge clk);
        chk("rst_state", o_State, 0); chk("rst_lives", o_Lives, 3); chk("rst_level", o_Level, 1);
        chk("rst_freeze", o_Freeze, 1); chk("rst_resp", o_Respawn, 0);
        chk("rst_units", o_Units, 1); chk("rst_tens", o_Tens, 0);
        #1 rst_n = 1'b1;
        cyc(1, 0, 500);
        chk("start_state", o_State, 1); chk("start_resp", o_Respawn, 1); chk("start_freeze", o_Freeze, 0);
        cyc(0, 0, 500);
        chk("resp_once", o_Respawn, 0);
        cnt = 0; rsp = 0;
        for (int i = 0; i < 20; i++) begin
            cyc(0, 1, 500);
            if (o_State == 3'd2) cnt++;
            if (o_Respawn) rsp++;
        end
        chk("hold_hit_len", cnt, 4); chk("hold_lives", o_Lives, 2); chk("hold_resp", rsp, 1);
        chk("hold_state", o_State, 1);
        cyc(0, 0, 500);
        cyc(0, 1, 500);
        chk("rise2_state", o_State, 2); chk("rise2_lives", o_Lives, 1);
        repeat (5) cyc(0, 0, 500);
        chk("back_play", o_State, 1);
        cyc(0, 1, 500);
        chk("over_state", o_State, 4); chk("over_lives", o_Lives, 0);
        cyc(0, 0, 500);
        chk("over_hold", o_State, 4);
        cyc(1, 0, 500);
        chk("restart_state", o_State, 0); chk("restart_lives", o_Lives, 3); chk("restart_level", o_Level, 1);
        cyc(0, 0, 500);
        chk("idle_hold", o_State, 0);
        cyc(1, 0, 500);
        chk("play2", o_State, 1);
        for (int k = 0; k < 8; k++) begin
            cyc(0, 0, 0);
            chk("lu_level", o_Level, k + 2);
            cnt = (o_State == 3'd3) ? 1 : 0;
            repeat (3) begin
                cyc(0, 0, 500);
                if (o_State == 3'd3) cnt++;
            end
            chk("lu_len", cnt, 3);
        end
        chk("lvl9", o_Level, 9); chk("lvl9_units", o_Units, 9);
        cyc(0, 0, 0);
        chk("wrap_state", o_State, 3); chk("wrap_level", o_Level, 1);
        chk("wrap_units", o_Units, 1); chk("wrap_tens", o_Tens, 0);
        repeat (3) cyc(0, 0, 500);
        cyc(0, 1, 0);
        chk("both_state", o_State, 2); chk("both_lives", o_Lives, 2); chk("both_level", o_Level, 1);
        cyc(0, 1, 500);
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_state", o_State, 0); chk("mid_rst_lives", o_Lives, 3);
        chk("mid_rst_freeze", o_Freeze, 1); chk("mid_rst_resp", o_Respawn, 0);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            cyc($urandom_range(0, 15) == 0, ($urandom_range(0, 5) == 0) ? ~coll : coll,
                ($urandom_range(0, 11) == 0) ? 10'd0 : 10'($urandom_range(1, 1023)));
            if ($urandom_range(0, 599) == 0) begin
                #1 rst_n = 1'b0;
                @(negedge clk);
                #1 rst_n = 1'b1;
            end
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
